pe_out_buffer: RTL
==================

PE_OUT_BUFFER -- requirements
Module: pe_out_buffer

Interface
REQ-001 Parameter WIDTH, default 32: data width; matches the ALU data_out width.
REQ-002 Parameter DEPTH, default 2: FIFO entries; legal values 2 or 4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_data  input  WIDTH  result word from the ALU data_out.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out_data  output  WIDTH  head-of-FIFO word.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  consumer takes out_data this cycle.
REQ-011 acc_en  input  1  config bit, static after configuration: 0 = PASS mode, 1 = ACC mode.
REQ-012 acc_len  input  4  config bits, static: ACC mode sums acc_len+1 inputs per output.
REQ-013 acc_busy  output  1  high while an ACC-mode partial sum is pending (cnt != 0).

Function
REQ-014 Accept condition: a word is accepted on a rising edge where in_valid && in_ready.
REQ-015 Pop condition: a word is popped on a rising edge where out_valid && out_ready.
REQ-016 in_ready SHALL be high exactly when occupancy < DEPTH, in both modes; there is no combinational path from out_ready to in_ready.
REQ-017 out_valid SHALL be high exactly when occupancy != 0; out_data SHALL be the oldest stored word, from registers with no combinational path from in_data.
REQ-018 PASS mode: each accepted word is written to the FIFO tail.
REQ-018 (cont.) Latency: in_data is accepted at edge N, is visible on out_data, and out_valid is high, after edge N.
REQ-019 ACC mode: an internal WIDTH-bit accumulator acc and a 4-bit counter cnt form a two-state machine.
REQ-019 (cont.) State COLLECT (cnt < acc_len): on accept, acc <= (cnt==0 ? in_data : acc+in_data) and cnt <= cnt+1.
REQ-020 State EMIT (on accept with cnt==acc_len): enqueue (cnt==0 ? in_data : acc+in_data), then set cnt <= 0 and acc <= 0.
REQ-020 (cont.) With acc_len==0, ACC mode behaves exactly as PASS mode.
REQ-021 Arithmetic: the sum is unsigned and modulo 2^WIDTH; carry-out is discarded.
REQ-022 Occupancy rules per edge:
- push only: +1.
- pop only: -1.
- push and pop together: unchanged; this is legal only when 0 < occupancy < DEPTH.
- A COLLECT accept does not push.
REQ-023 Full FIFO: in_ready is 0, so in_data is held and acc/cnt are not updated until a pop frees an entry.
REQ-024 Empty FIFO: a pop request is ignored, out_valid stays 0, and the read pointer holds.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated words.
REQ-026 Changing acc_en or acc_len while acc_busy==1 or occupancy != 0 is illegal; behaviour in that case is unspecified, but the block SHALL NOT deadlock.

Reset
REQ-027 While rst_n==0:
- occupancy, pointers, cnt and acc are 0.
- out_valid=0, in_ready=0, acc_busy=0, out_data=0.
REQ-028 in_ready SHALL rise on the first rising edge after rst_n deasserts.
REQ-029 Reset asserted mid-accumulation or mid-drain SHALL discard all partial sums and stored words immediately, asynchronously.

Verification
REQ-030 PASS, DEPTH=2, out_ready=0; push 0x11, 0x22, 0x33 -> in_ready=0 after the second accept and 0x33 is held; raise out_ready -> outputs 0x11, 0x22, 0x33 in order.
REQ-031 ACC, acc_len=3, inputs 1,2,3,4 with out_ready=1 -> single output 0x0000000A, one cycle after the 4th accept; acc_busy high between the first and fourth accepts.
REQ-032 ACC, acc_len=1, inputs 0xFFFFFFFF and 0x00000002 -> output 0x00000001 (wraps).
REQ-033 Reset pulse after 2 of 4 ACC inputs, then inputs 5,5,5,5 -> output 0x00000014; no stale value appears.
REQ-034 PASS with random in_valid/out_ready over 1000 words -> output order equals input order, no drops or duplicates, and pointers wrap with both DEPTH=2 and DEPTH=4.
REQ-035 Simultaneous push/pop at occupancy 1 -> occupancy stays 1 and out_valid stays continuously high.

Source files
------------

// File: rtl/pe_out_buffer.sv
// Output buffer for a processing element: small FIFO on the ALU result stream,
// with an optional accumulate mode that sums acc_len+1 inputs into one output word.
module pe_out_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             acc_en,
  input  logic [3:0]       acc_len,
  output logic             acc_busy
);

  // DEPTH is 2 or 4, so pointers wrap naturally at their own width
  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } acc_state_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             acc_busy_q, acc_busy_d;

  acc_state_e       state_s;
  logic             accept_s;
  logic             pop_s;
  logic             push_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] push_data_s;

  // Next-state logic: handshakes, accumulator machine, FIFO pointers and flags
  always_comb begin
    accept_s    = in_valid && in_ready_q;
    pop_s       = out_valid_q && out_ready;
    sum_s       = (cnt_q == 4'd0) ? in_data : (acc_q + in_data);
    push_data_s = acc_en ? sum_s : in_data;
    push_s      = 1'b0;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;

    // cnt >= acc_len emits so an illegal mid-sum acc_len change cannot stall the counter
    if (acc_en && (cnt_q < acc_len)) begin
      state_s = ST_COLLECT;
    end else begin
      state_s = ST_EMIT;
    end

    if (accept_s) begin
      case (state_s)
        ST_COLLECT: begin
          acc_d = sum_s;
          cnt_d = cnt_q + 4'd1;
        end
        ST_EMIT: begin
          push_s = 1'b1;
          acc_d  = {WIDTH{1'b0}};
          cnt_d  = 4'd0;
        end
        default: begin
          acc_d = {WIDTH{1'b0}};
          cnt_d = 4'd0;
        end
      endcase
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end

    if (push_s) begin
      mem_d[wr_ptr_q] = push_data_s;
      wr_ptr_d        = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   occ_d = occ_q - {{(CW-1){1'b0}}, 1'b1};
      default: occ_d = occ_q;
    endcase

    in_ready_d  = (occ_d < DEPTH_C);
    out_valid_d = (occ_d != {CW{1'b0}});
    acc_busy_d  = (cnt_d != 4'd0);
  end

  // State registers; reset discards stored words and any partial sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      occ_q       <= {CW{1'b0}};
      cnt_q       <= 4'd0;
      acc_q       <= {WIDTH{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_busy_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      acc_busy_q  <= acc_busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_busy  = acc_busy_q;
  assign out_data  = mem_q[rd_ptr_q];

endmodule
